// File: rtl/estacionamiento_pkg.sv
// Shared definitions for the multi-lane parking occupancy counter.
//   lane_state_e : 3-bit encoding of a lane's passage-tracking FSM
//   lane_event_e : event a lane reports on the cycle a passage completes
package estacionamiento_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IN1  = 3'd1,
    ST_IN2  = 3'd2,
    ST_IN3  = 3'd3,
    ST_OUT1 = 3'd4,
    ST_OUT2 = 3'd5,
    ST_OUT3 = 3'd6,
    ST_ERR  = 3'd7
  } lane_state_e;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_ENTRY = 2'd1,
    EV_EXIT  = 2'd2
  } lane_event_e;

endpackage

// File: rtl/estacionamiento_multi_carril.sv
// carril_fsm: one entry/exit lane.
// Synchronizes the outer (psensor_i) and inner (ssensor_i) sensors with
// two flops each, then tracks the passage with an 8-state FSM.
// Ports:
//   clk, reset      : system clock, asynchronous active-low reset
//   psensor_i       : street-side sensor, asynchronous to clk
//   ssensor_i       : lot-side sensor, asynchronous to clk
//   entry_o         : one-cycle pulse on the edge-ahead cycle a car finishes entering
//   exit_o          : one-cycle pulse on the edge-ahead cycle a car finishes leaving
//   err_o           : high while the lane sits in its error state
module carril_fsm
  import estacionamiento_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic psensor_i,
  input  logic ssensor_i,
  output logic entry_o,
  output logic exit_o,
  output logic err_o
);

  logic [1:0]  p_sync_q;
  logic [1:0]  s_sync_q;
  logic [1:0]  ps;
  lane_state_e state_q;
  lane_state_e state_d;
  lane_event_e ev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_sync_q <= '0;
      s_sync_q <= '0;
    end else begin
      p_sync_q <= {p_sync_q[0], psensor_i};
      s_sync_q <= {s_sync_q[0], ssensor_i};
    end
  end

  // {p, s} as seen after synchronization
  assign ps = {p_sync_q[1], s_sync_q[1]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state. The OUT branch is the IN branch with p and s swapped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        case (ps)
          2'b10:   state_d = ST_IN1;
          2'b01:   state_d = ST_OUT1;
          2'b11:   state_d = ST_ERR;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_IN1: begin
        case (ps)
          2'b11:   state_d = ST_IN2;
          2'b00:   state_d = ST_IDLE;  // car backed out
          2'b01:   state_d = ST_ERR;
          default: state_d = ST_IN1;
        endcase
      end
      ST_IN2: begin
        case (ps)
          2'b01:   state_d = ST_IN3;
          2'b10:   state_d = ST_IN1;
          2'b00:   state_d = ST_ERR;
          default: state_d = ST_IN2;
        endcase
      end
      ST_IN3: begin
        case (ps)
          2'b00:   state_d = ST_IDLE;
          2'b11:   state_d = ST_IN2;
          2'b10:   state_d = ST_ERR;
          default: state_d = ST_IN3;
        endcase
      end
      ST_OUT1: begin
        case (ps)
          2'b11:   state_d = ST_OUT2;
          2'b00:   state_d = ST_IDLE;
          2'b10:   state_d = ST_ERR;
          default: state_d = ST_OUT1;
        endcase
      end
      ST_OUT2: begin
        case (ps)
          2'b10:   state_d = ST_OUT3;
          2'b01:   state_d = ST_OUT1;
          2'b00:   state_d = ST_ERR;
          default: state_d = ST_OUT2;
        endcase
      end
      ST_OUT3: begin
        case (ps)
          2'b00:   state_d = ST_IDLE;
          2'b11:   state_d = ST_OUT2;
          2'b01:   state_d = ST_ERR;
          default: state_d = ST_OUT3;
        endcase
      end
      ST_ERR: begin
        if (ps == 2'b00) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. Events are Mealy so the counter updates on the same edge
  // that returns the lane to IDLE.
  always_comb begin
    ev = EV_NONE;
    if (ps == 2'b00) begin
      if (state_q == ST_IN3)  ev = EV_ENTRY;
      if (state_q == ST_OUT3) ev = EV_EXIT;
    end
  end

  assign entry_o = (ev == EV_ENTRY);
  assign exit_o  = (ev == EV_EXIT);
  assign err_o   = (state_q == ST_ERR);

endmodule

// File: rtl/estacionamiento_multi.sv
// estacionamiento_multi: parking-lot occupancy counter with LANES
// independent entry/exit lanes.
// Ports:
//   clk, reset            : system clock, asynchronous active-low reset
//   psensor, ssensor      : per-lane outer/inner sensors (asynchronous)
//   clear_err             : synchronous clear of the sticky overflow/underflow
//   conteo                : registered occupancy
//   lleno, vacio          : conteo == CAPACITY / conteo == 0
//   lane_error, hubo_error: per-lane error state and its OR
//   overflow, underflow   : sticky saturation flags
module estacionamiento_multi
  import estacionamiento_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int N        = 8,
  parameter int CAPACITY = 200
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] psensor,
  input  logic [LANES-1:0] ssensor,
  input  logic             clear_err,
  output logic [N-1:0]     conteo,
  output logic             lleno,
  output logic             vacio,
  output logic [LANES-1:0] lane_error,
  output logic             hubo_error,
  output logic             overflow,
  output logic             underflow
);

  // Wide enough for conteo + LANES - 0 and 0 - LANES without wrapping
  localparam int SW = N + 2 + $clog2(LANES);
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [LANES-1:0]     entry;
  logic [LANES-1:0]     exit_ev;
  logic signed [SW-1:0] sum;
  logic                 set_ov;
  logic                 set_un;
  logic [N-1:0]         conteo_q, conteo_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    carril_fsm u_carril (
      .clk       (clk),
      .reset     (reset),
      .psensor_i (psensor[i]),
      .ssensor_i (ssensor[i]),
      .entry_o   (entry[i]),
      .exit_o    (exit_ev[i]),
      .err_o     (lane_error[i])
    );
  end

  // Net change this cycle; simultaneous entries and exits cancel before
  // the range check, so only the net result can raise a flag.
  always_comb begin
    sum = $signed({{(SW-N){1'b0}}, conteo_q});
    for (int i = 0; i < LANES; i++) begin
      sum = sum + $signed({{(SW-1){1'b0}}, entry[i]});
      sum = sum - $signed({{(SW-1){1'b0}}, exit_ev[i]});
    end
  end

  always_comb begin
    set_ov   = 1'b0;
    set_un   = 1'b0;
    conteo_d = N'(sum);
    if (sum > CAP_S) begin
      set_ov   = 1'b1;
      conteo_d = N'(CAPACITY);
    end else if (sum < 0) begin
      set_un   = 1'b1;
      conteo_d = '0;
    end
  end

  // A new saturation in the clear cycle keeps the flag set
  assign overflow_d  = set_ov | (overflow_q  & ~clear_err);
  assign underflow_d = set_un | (underflow_q & ~clear_err);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conteo_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      conteo_q    <= conteo_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign conteo     = conteo_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign lleno      = (conteo_q == N'(CAPACITY));
  assign vacio      = (conteo_q == '0);
  assign hubo_error = |lane_error;

endmodule

// File: tb/tb_estacionamiento_multi.sv
module tb_estacionamiento_multi;

  localparam int LANES    = 2;
  localparam int N        = 4;
  localparam int CAPACITY = 10;
  // {conteo, lleno, vacio, lane_error, hubo_error, overflow, underflow}
  localparam int VW       = N + LANES + 5;

  logic             clk;
  logic             reset;
  logic [LANES-1:0] psensor;
  logic [LANES-1:0] ssensor;
  logic             clear_err;
  logic [N-1:0]     conteo;
  logic             lleno;
  logic             vacio;
  logic [LANES-1:0] lane_error;
  logic             hubo_error;
  logic             overflow;
  logic             underflow;

  int n_vec = 0;
  int n_err = 0;

  logic [VW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  estacionamiento_multi #(.LANES(LANES), .N(N), .CAPACITY(CAPACITY)) dut (
    .clk        (clk),
    .reset      (reset),
    .psensor    (psensor),
    .ssensor    (ssensor),
    .clear_err  (clear_err),
    .conteo     (conteo),
    .lleno      (lleno),
    .vacio      (vacio),
    .lane_error (lane_error),
    .hubo_error (hubo_error),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // ---------------- reference model ----------------
  // A passage is a walk along a path of sensor patterns; a lane is idle,
  // walking the entry path, walking the exit path, or jammed.
  // Pattern k of a path is path[2k +: 2], pattern = {p, s}.
  logic [9:0] in_path  = {2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [9:0] out_path = {2'b00, 2'b10, 2'b11, 2'b01, 2'b00};

  int m_mode[LANES];   // 0 idle, 1 entering, 2 leaving, 3 jammed
  int m_pos[LANES];    // position along the current path
  int m_cnt;
  logic m_ov, m_un;
  // inputs as seen one and two edges ago
  logic [LANES-1:0] dp1, ds1, dp2, ds2;

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_mode[i] = 0;
      m_pos[i]  = 0;
    end
    m_cnt = 0;
    m_ov  = 1'b0;
    m_un  = 1'b0;
    dp1 = '0; ds1 = '0; dp2 = '0; ds2 = '0;
  endtask

  task automatic model_lane(input int i, input logic [1:0] pat, output int ev);
    logic [9:0] path;
    int k;
    ev = 0;
    if (m_mode[i] == 3) begin
      if (pat == 2'b00) m_mode[i] = 0;
    end else if (m_mode[i] == 0) begin
      if (pat == 2'b10)      begin m_mode[i] = 1; m_pos[i] = 1; end
      else if (pat == 2'b01) begin m_mode[i] = 2; m_pos[i] = 1; end
      else if (pat == 2'b11) m_mode[i] = 3;
    end else begin
      path = (m_mode[i] == 1) ? in_path : out_path;
      k = m_pos[i];
      if (pat == path[2*k +: 2]) begin
        // holding position
      end else if (pat == path[2*(k+1) +: 2]) begin
        if (k == 3) begin
          ev = (m_mode[i] == 1) ? 1 : -1;
          m_mode[i] = 0;
        end else begin
          m_pos[i] = k + 1;
        end
      end else if (pat == path[2*(k-1) +: 2]) begin
        if (k == 1) m_mode[i] = 0;
        else        m_pos[i] = k - 1;
      end else begin
        m_mode[i] = 3;
      end
    end
  endtask

  task automatic model_edge(input logic [LANES-1:0] p, input logic [LANES-1:0] s,
                            input logic clr);
    int ev;
    int net;
    net = 0;
    for (int i = 0; i < LANES; i++) begin
      model_lane(i, {dp2[i], ds2[i]}, ev);
      net += ev;
    end
    dp2 = dp1; ds2 = ds1;
    dp1 = p;   ds1 = s;
    if (m_cnt + net > CAPACITY) begin
      m_cnt = CAPACITY;
      m_ov  = 1'b1;
      if (clr) m_un = 1'b0;
    end else if (m_cnt + net < 0) begin
      m_cnt = 0;
      m_un  = 1'b1;
      if (clr) m_ov = 1'b0;
    end else begin
      m_cnt = m_cnt + net;
      if (clr) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [LANES-1:0] le;
    logic [31:0] c;
    c = m_cnt;
    for (int i = 0; i < LANES; i++) le[i] = (m_mode[i] == 3);
    return {c[N-1:0], (m_cnt == CAPACITY), (m_cnt == 0), le, |le, m_ov, m_un};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_model(input string tag);
    logic [VW-1:0] got, exp;
    exp_q.push_back(model_vec());
    got = {conteo, lleno, vacio, lane_error, hubo_error, overflow, underflow};
    exp = exp_q.pop_front();
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input logic [LANES-1:0] p, input logic [LANES-1:0] s,
                       input logic clr);
    psensor   = p;
    ssensor   = s;
    clear_err = clr;
    @(posedge clk);
    model_edge(p, s, clr);
    #1;
    check_model("cycle");
    @(negedge clk);
  endtask

  // l0/l1 are {p, s} for lane 0 / lane 1
  task automatic drive2(input logic [1:0] l0, input logic [1:0] l1, input int n);
    for (int c = 0; c < n; c++) cycle({l1[1], l0[1]}, {l1[0], l0[0]}, 1'b0);
  endtask

  task automatic do_entry(input int lane);
    for (int k = 1; k <= 4; k++) begin
      if (lane == 0) drive2(in_path[2*k +: 2], 2'b00, 3);
      else           drive2(2'b00, in_path[2*k +: 2], 3);
    end
  endtask

  // Asserts reset mid-cycle, holds it across two edges, releases at a negedge.
  task automatic pulse_reset(input logic [1:0] l0, input logic [1:0] l1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_model("async_reset");
    psensor = {l1[1], l0[1]};
    ssensor = {l1[0], l0[0]};
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model("held_reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] scr[LANES][5];
    logic [LANES-1:0] p, s;
    int kind;
    int hold;

    reset = 1'b0;
    psensor = '0;
    ssensor = '0;
    clear_err = 1'b0;
    model_reset();
    #1;
    chk("rst_conteo", 32'(conteo), 0);
    chk("rst_vacio", 32'(vacio), 1);
    chk("rst_lleno", 32'(lleno), 0);
    chk("rst_lane_error", 32'(lane_error), 0);
    chk("rst_flags", {30'd0, overflow, underflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // one entry on lane 0
    drive2(2'b00, 2'b00, 3);
    do_entry(0);
    chk("entry_conteo", 32'(conteo), 1);
    chk("entry_vacio", 32'(vacio), 0);
    chk("entry_hubo", 32'(hubo_error), 0);

    // exit on an empty lot saturates at zero
    pulse_reset(2'b00, 2'b00);
    drive2(2'b00, 2'b00, 3);
    drive2(2'b00, 2'b01, 3);
    drive2(2'b00, 2'b11, 3);
    drive2(2'b00, 2'b10, 3);
    drive2(2'b00, 2'b00, 3);
    chk("under_conteo", 32'(conteo), 0);
    chk("under_flag", 32'(underflow), 1);
    cycle('0, '0, 1'b1);
    chk("under_clear", 32'(underflow), 0);

    // simultaneous entry and exit cancel at conteo = 5
    pulse_reset(2'b00, 2'b00);
    for (int j = 0; j < 5; j++) do_entry(0);
    chk("five_conteo", 32'(conteo), 5);
    drive2(2'b10, 2'b01, 3);
    drive2(2'b11, 2'b11, 3);
    drive2(2'b01, 2'b10, 3);
    drive2(2'b00, 2'b00, 3);
    chk("cancel_conteo", 32'(conteo), 5);
    chk("cancel_flags", {30'd0, overflow, underflow}, 0);

    // fill to capacity, then one more
    pulse_reset(2'b00, 2'b00);
    for (int j = 0; j < 10; j++) do_entry(j % 2);
    chk("full_conteo", 32'(conteo), 10);
    chk("full_lleno", 32'(lleno), 1);
    chk("full_no_ov", 32'(overflow), 0);
    do_entry(1);
    chk("over_conteo", 32'(conteo), 10);
    chk("over_flag", 32'(overflow), 1);

    // lane 1 jumps straight to both sensors
    drive2(2'b00, 2'b11, 3);
    chk("err_lane_error", 32'(lane_error), 2);
    chk("err_hubo", 32'(hubo_error), 1);
    chk("err_conteo", 32'(conteo), 10);
    drive2(2'b00, 2'b00, 2);
    chk("err_still", 32'(lane_error), 2);
    drive2(2'b00, 2'b00, 1);
    chk("err_cleared", 32'(lane_error), 0);

    // reset while lane 0 is mid-entry, release with both sensors active
    pulse_reset(2'b00, 2'b00);
    for (int j = 0; j < 3; j++) do_entry(0);
    drive2(2'b10, 2'b00, 3);
    drive2(2'b11, 2'b00, 3);
    chk("mid_conteo", 32'(conteo), 3);
    pulse_reset(2'b11, 2'b00);
    chk("mid_rst_conteo", 32'(conteo), 0);
    chk("mid_rst_err", 32'(lane_error), 0);
    drive2(2'b11, 2'b00, 3);
    chk("mid_rel_err", 32'(lane_error), 1);
    drive2(2'b00, 2'b00, 4);
    chk("mid_rel_idle", 32'(lane_error), 0);

    // randomized passages, glitches and clears on both lanes
    pulse_reset(2'b00, 2'b00);
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < LANES; i++) begin
        kind = $urandom_range(0, 4);
        for (int k = 0; k < 5; k++) begin
          case (kind)
            0, 1:    scr[i][k] = in_path[2*k +: 2];
            2:       scr[i][k] = out_path[2*k +: 2];
            3:       scr[i][k] = (k == 1) ? 2'b10 : 2'b00;
            default: scr[i][k] = (k == 0 || k == 4) ? 2'b00 : 2'($urandom_range(0, 3));
          endcase
        end
      end
      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < LANES; i++) begin
          p[i] = scr[i][k][1];
          s[i] = scr[i][k][0];
        end
        hold = (k == 4) ? 3 : $urandom_range(1, 4);
        for (int c = 0; c < hold; c++) cycle(p, s, ($urandom_range(0, 9) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
